// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_pkg
// Brief   : Shared types for the multi-channel LED pattern generator.
// Revision: 1.0 - initial release
// ============================================================================
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF   = 2'b00,
      LED_ON    = 2'b01,
      LED_BLINK = 2'b10,
      LED_PWM   = 2'b11
   } led_mode_t;

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
// Module  : led_channel
// Brief   : One LED channel: config registers, blink counter and output bit.
// Revision: 1.0 - initial release
// ============================================================================
module led_channel
   import led_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int PWM_W = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             tick,
   input  logic [PWM_W-1:0] pwm_phase,
   input  logic             we,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [PWM_W-1:0] cfg_duty,
   output logic             led
);

   led_mode_t        r_mode;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_cnt;
   logic [PWM_W-1:0] r_duty;
   logic             r_led;

   // A write restarts the channel and takes priority over a coincident tick.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_mode   <= LED_OFF;
         r_period <= CNT_W'(1);
         r_duty   <= '0;
         r_cnt    <= '0;
         r_led    <= 1'b0;
      end else if (we) begin
         r_mode   <= led_mode_t'(cfg_mode);
         r_period <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
         r_duty   <= cfg_duty;
         r_cnt    <= '0;
         r_led    <= (led_mode_t'(cfg_mode) == LED_ON);
      end else begin
         case (r_mode)
            LED_OFF: r_led <= 1'b0;
            LED_ON:  r_led <= 1'b1;
            LED_BLINK: begin
               if (tick) begin
                  if (r_cnt == r_period - CNT_W'(1)) begin
                     r_cnt <= '0;
                     r_led <= ~r_led;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            LED_PWM: r_led <= (pwm_phase < r_duty);
         endcase
      end
   end

   assign led = r_led;

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : led_pattern_gen
// Brief   : NB_CH-channel LED generator (OFF/ON/BLINK/PWM) on a shared tick.
// Revision: 1.0 - initial release
// ============================================================================
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int NB_CH    = 8,
   parameter int PRESCALE = 1000,
   parameter int CNT_W    = 16,
   parameter int PWM_W    = 8
) (
   input  logic                                      sys_clk,
   input  logic                                      sys_rst_n,
   input  logic                                      cfg_we,
   input  logic [((NB_CH > 1) ? $clog2(NB_CH) : 1)-1:0] cfg_ch,
   input  logic [1:0]                                cfg_mode,
   input  logic [CNT_W-1:0]                          cfg_period,
   input  logic [PWM_W-1:0]                          cfg_duty,
   output logic [NB_CH-1:0]                          led,
   output logic                                      tick
);

   localparam int c_CH_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;
   localparam int c_PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(PRESCALE - 1);

   logic [c_PS_W-1:0] r_presc;
   logic              r_tick;
   logic [PWM_W-1:0]  r_phase;
   logic [NB_CH-1:0]  w_we;

   // Tick is registered, so it lands one cycle after the prescaler hits its top.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_phase <= '0;
      end else begin
         r_tick  <= (r_presc == c_PS_MAX);
         r_presc <= (r_presc == c_PS_MAX) ? '0 : r_presc + c_PS_W'(1);
         if (r_tick) begin
            r_phase <= r_phase + PWM_W'(1);
         end
      end
   end

   assign tick = r_tick;

   // Out-of-range channel numbers never match a decode line and are dropped.
   for (genvar i = 0; i < NB_CH; i++) begin : g_ch
      assign w_we[i] = cfg_we & (cfg_ch == c_CH_W'(i));

      led_channel #(
         .CNT_W (CNT_W),
         .PWM_W (PWM_W)
      ) u_channel (
         .sys_clk    (sys_clk),
         .sys_rst_n  (sys_rst_n),
         .tick       (r_tick),
         .pwm_phase  (r_phase),
         .we         (w_we[i]),
         .cfg_mode   (cfg_mode),
         .cfg_period (cfg_period),
         .cfg_duty   (cfg_duty),
         .led        (led[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_pattern_gen
// Brief   : Self-checking bench for led_pattern_gen against a cycle-count model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;
   import led_pkg::*;

   localparam int NB_CH    = 6;
   localparam int PRESCALE = 4;
   localparam int CNT_W    = 8;
   localparam int PWM_W    = 4;
   localparam int CH_W     = 3;

   logic             sys_clk    = 1'b0;
   logic             sys_rst_n  = 1'b0;
   logic             cfg_we     = 1'b0;
   logic [CH_W-1:0]  cfg_ch     = '0;
   logic [1:0]       cfg_mode   = '0;
   logic [CNT_W-1:0] cfg_period = '0;
   logic [PWM_W-1:0] cfg_duty   = '0;
   logic [NB_CH-1:0] led;
   logic             tick;

   int n_cmp = 0;
   int n_mis = 0;

   led_pattern_gen #(
      .NB_CH    (NB_CH),
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W),
      .PWM_W    (PWM_W)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .led        (led),
      .tick       (tick)
   );

   always #5 sys_clk = ~sys_clk;

   // Model: n = clock edges since reset release; each channel remembers the
   // edge of its last write and its settings, outputs follow by arithmetic.
   int n = 0;
   int m_tw   [NB_CH] = '{default: 0};
   int m_mode [NB_CH] = '{default: 0};
   int m_per  [NB_CH] = '{default: 1};
   int m_duty [NB_CH] = '{default: 0};

   function automatic int ntick(input int a);
      return (a <= 0) ? 0 : a / PRESCALE;
   endfunction

   function automatic logic exp_led(input int c);
      if (n == m_tw[c]) return (m_mode[c] == 1);
      case (m_mode[c])
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (((ntick(n - 1) - ntick(m_tw[c] - 1)) / m_per[c]) % 2) == 1;
         default: return (ntick(n - 2) % (1 << PWM_W)) < m_duty[c];
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge sys_clk) begin
      logic [NB_CH-1:0] e;
      if (!sys_rst_n) begin
         n = 0;
         for (int c = 0; c < NB_CH; c++) begin
            m_tw[c] = 0; m_mode[c] = 0; m_per[c] = 1; m_duty[c] = 0;
         end
      end else begin
         n++;
         if (cfg_we && int'(cfg_ch) < NB_CH) begin
            m_tw[cfg_ch]   = n;
            m_mode[cfg_ch] = int'(cfg_mode);
            m_per[cfg_ch]  = (cfg_period == '0) ? 1 : int'(cfg_period);
            m_duty[cfg_ch] = int'(cfg_duty);
         end
      end
      #1;
      for (int c = 0; c < NB_CH; c++) e[c] = exp_led(c);
      chk("model_led", int'(led), int'(e));
      chk("model_tick", int'(tick), int'(n > 0 && n % PRESCALE == 0));
   end

   task automatic wr(input int ch, input logic [1:0] mode, input int per, input int duty);
      cfg_we     = 1'b1;
      cfg_ch     = CH_W'(ch);
      cfg_mode   = mode;
      cfg_period = CNT_W'(per);
      cfg_duty   = PWM_W'(duty);
      @(negedge sys_clk);
      cfg_we = 1'b0;
   endtask

   task automatic count_tick(output int cnt);
      cnt = 0;
      while (!tick && cnt < 50) begin
         @(negedge sys_clk);
         cnt++;
      end
   endtask

   task automatic count_until(input int ch, input logic val, output int cnt);
      cnt = 0;
      do begin
         @(negedge sys_clk);
         cnt++;
      end while (led[ch] !== val && cnt < 200);
   endtask

   task automatic count_high(input int ch, output int hi);
      hi = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge sys_clk);
         if (led[ch]) hi++;
      end
   endtask

   initial begin
      int cnt;
      logic [NB_CH-1:0] snap;

      repeat (3) @(negedge sys_clk);
      chk("reset_led", int'(led), 0);
      chk("reset_tick", int'(tick), 0);
      sys_rst_n = 1'b1;
      count_tick(cnt);
      chk("t1_first_tick", cnt, 4);

      // T1: async reset clears outputs without a clock edge
      wr(0, LED_ON, 1, 0);
      chk("t1_on", int'(led[0]), 1);
      #2 sys_rst_n = 1'b0;
      #1 chk("t1_async_led", int'(led), 0);
      chk("t1_async_tick", int'(tick), 0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      count_tick(cnt);
      chk("t1_tick_after_release", cnt, 4);

      // T2: blink period 3 toggles every 12 cycles
      wr(2, LED_BLINK, 3, 0);
      chk("t2_write_low", int'(led[2]), 0);
      count_until(2, 1'b1, cnt);
      chk("t2_rise", cnt, 12);
      count_until(2, 1'b0, cnt);
      chk("t2_fall", cnt, 12);
      chk("t2_others", int'(led & 6'b111011), 0);

      // T3: PWM duty over a 64-cycle frame (16 ticks of 4 cycles)
      wr(1, LED_PWM, 0, 4);
      count_high(1, cnt);
      chk("t3_duty4", cnt, 16);
      wr(1, LED_PWM, 0, 15);
      count_high(1, cnt);
      chk("t3_duty_max", cnt, 60);
      wr(1, LED_PWM, 0, 0);
      count_high(1, cnt);
      chk("t3_duty0", cnt, 0);

      // T4: ON for exactly one cycle, neighbours undisturbed
      wr(4, LED_ON, 1, 0);
      wr(5, LED_ON, 1, 0);
      chk("t4_on", int'(led[5]), 1);
      wr(5, LED_OFF, 1, 0);
      chk("t4_off", int'(led[5]), 0);
      chk("t4_neigh4", int'(led[4]), 1);

      // T5: write colliding with a tick restarts the blink phase
      wr(3, LED_BLINK, 1, 0);
      cnt = 0;
      do begin
         @(negedge sys_clk);
         cnt++;
      end while (!(tick && led[3]) && cnt < 100);
      chk("t5_align", int'(tick & led[3]), 1);
      wr(3, LED_BLINK, 1, 0);
      chk("t5_cleared", int'(led[3]), 0);
      count_until(3, 1'b1, cnt);
      chk("t5_next_toggle", cnt, PRESCALE);

      // T6: out-of-range channel ignored, period 0 acts as 1
      snap = led;
      wr(7, LED_ON, 1, 0);
      chk("t6_ch7", int'(led), int'(snap));
      snap = led;
      wr(6, LED_ON, 1, 0);
      chk("t6_ch6", int'(led), int'(snap));
      count_tick(cnt);
      wr(2, LED_BLINK, 0, 0);
      count_until(2, 1'b1, cnt);
      chk("t6_period0_rise", cnt, PRESCALE);
      count_until(2, 1'b0, cnt);
      chk("t6_period0_fall", cnt, PRESCALE);

      // Random traffic, including out-of-range channels and mid-run resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge sys_clk);
         cfg_we = 1'b0;
         if ($urandom_range(0, 7) < 2) begin
            cfg_we     = 1'b1;
            cfg_ch     = CH_W'($urandom_range(0, 7));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = CNT_W'($urandom_range(0, 3));
            cfg_duty   = PWM_W'($urandom_range(0, 15));
         end else if ($urandom_range(0, 199) == 0) begin
            #2 sys_rst_n = 1'b0;
            #1 chk("rnd_async_led", int'(led), 0);
            @(negedge sys_clk);
            @(negedge sys_clk);
            sys_rst_n = 1'b1;
         end
      end
      @(negedge sys_clk);
      cfg_we = 1'b0;
      repeat (4) @(negedge sys_clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
